alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single 32-bit ALU between two requesters (port 0: integer datapath, port 1: address/debug unit) using a valid/ready handshake on each request port and one tagged response port. The block grants one request at a time, registers the operands, runs them through the ALU, and holds a registered result until it is consumed. It sits between the decode/issue logic and the ALU instance, and it is the only driver of the ALU inputs.

## Interface
- `RR_ENABLE`, default 1: 1 = round-robin arbitration; 0 = fixed priority, port 0 wins.
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `req_valid` input, 2 bits: bit i asserted means port i presents a request.
- `req_ready` output, 2 bits: bit i asserted means port i's request is accepted this cycle. The grant is one-hot or zero.
- `req_op0`, `req_op1` input, 4 bits each: ALU operation. AND=0, OR=1, NOR=2, ADD=3, SUB=4, LUI=5, SLL=6, SRL=7.
- `req_a0`, `req_a1`, `req_b0`, `req_b1` input, 32 bits each: operands.
- `req_shamt0`, `req_shamt1` input, 5 bits each: shift amount.
- `rsp_valid` output, 1 bit: the response is valid.
- `rsp_ready` input, 1 bit: the consumer accepts the response.
- `rsp_id` output, 1 bit: the port that issued the response.
- `rsp_result` output, 32 bits: the ALU result.
- `rsp_zero` output, 1 bit: the result equals 0.
- `rsp_illegal` output, 1 bit: the op code was 8–15.

## Operation
- FSM states:
  - IDLE: `req_ready` may assert.
  - EXEC: the ALU inputs are driven from the operand registers.
  - RESP: `rsp_valid` is high.
- IDLE → EXEC when any `req_valid` bit is set. On this transition:
  - the granted port's op, A, B and shamt are captured.
  - the granted port's index is stored as `cur_id`.
  - the `last_grant` register is updated.
- EXEC → RESP unconditionally. On this transition:
  - the ALU result is captured into `rsp_result`.
  - the Zero output is captured into `rsp_zero`.
  - `rsp_illegal` is set to (op > 7).
- RESP → IDLE when `rsp_ready` is high. Otherwise the block stays in RESP and holds all `rsp_*` outputs stable.
- Arbitration, evaluated only in IDLE:
  - Only one port valid: that port is granted.
  - Both ports valid, `RR_ENABLE`=1: the port not equal to `last_grant` is granted.
  - Both ports valid, `RR_ENABLE`=0: port 0 is granted.
  - `req_ready` is combinational from the state, `req_valid` and `last_grant`. It is zero outside IDLE.
- Requesters must hold `req_*` stable while `req_valid` is high and `req_ready` is low. A requester that deasserts without a grant has no effect.
- Illegal op (8–15): the ALU returns 0. The response is still generated with `rsp_result`=0, `rsp_zero`=1 and `rsp_illegal`=1. The block never hangs.
- Width rules:
  - ADD and SUB wrap modulo 2^32, with no carry or overflow output.
  - SLL and SRL shift B by shamt with zero fill; A is ignored.
  - LUI produces {B[15:0], 16'h0000}.

## Timing
- Reset values:
  - state = IDLE.
  - `last_grant` = 1, so port 0 wins the first tie.
  - `req_ready` = 0.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_result` = 0, `rsp_zero` = 0, `rsp_illegal` = 0.
- Latency: a request accepted in cycle N gives `rsp_valid` high in cycle N+2.
- Best-case throughput: one operation per 3 cycles, with `rsp_ready` held high.
- Backpressure: the RESP state may last any number of cycles. No new request is accepted during EXEC or RESP.
- Reset mid-operation: everything returns to the reset values immediately. The in-flight operation is dropped and no response is produced.
- Both ports valid in consecutive IDLE windows with `RR_ENABLE`=1: grants strictly alternate 0, 1, 0, 1, …

## Structure
- Shared package `alu_pkg`:
  - the ALU op code constants (0–7).
  - the FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2).
  - `ALU_W` = 32.
- One sub-module: the existing `ALU`, instantiated once inside `alu_arbiter` and fed only from the operand registers.
- The arbitration logic stays inline; it is too small to justify its own module.

## Test plan
- Port 0 sends ADD, A=5, B=7, accepted in cycle N → `rsp_valid` in cycle N+2 with `rsp_result`=12, `rsp_zero`=0, `rsp_id`=0.
- Port 1 sends SUB, A=B=32'h0000_00FF → `rsp_result`=0, `rsp_zero`=1, `rsp_id`=1.
- Both ports hold ADD continuously, `RR_ENABLE`=1, `rsp_ready`=1 → `rsp_id` sequence 0, 1, 0, 1, with a response every 3 cycles. With `RR_ENABLE`=0 → `rsp_id` sequence 0, 0, 0.
- Port 0 sends SLL, B=1, shamt=31, and `rsp_ready` is held low for 5 cycles → `rsp_result`=32'h8000_0000 held stable and `req_ready`=0 throughout. The response is consumed on the 6th cycle and the block is in IDLE the cycle after.
- Port 1 sends op 4'hF → `rsp_result`=0, `rsp_zero`=1, `rsp_illegal`=1. The next request is then serviced normally.
- `reset` is asserted low during EXEC → all outputs return to their reset values asynchronously. After release, no stale response appears, and a new port 0 LUI with B=16'h1234 returns 32'h1234_0000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: datapath width, ALU op codes, FSM states.
package alu_pkg;

  localparam int ALU_W = 32;

  // ALU operation codes; 8..15 are illegal and yield a zero result.
  localparam logic [3:0] ALU_OP_AND = 4'd0;
  localparam logic [3:0] ALU_OP_OR  = 4'd1;
  localparam logic [3:0] ALU_OP_NOR = 4'd2;
  localparam logic [3:0] ALU_OP_ADD = 4'd3;
  localparam logic [3:0] ALU_OP_SUB = 4'd4;
  localparam logic [3:0] ALU_OP_LUI = 4'd5;
  localparam logic [3:0] ALU_OP_SLL = 4'd6;
  localparam logic [3:0] ALU_OP_SRL = 4'd7;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/ALU.sv
// Combinational 32-bit ALU. Illegal op codes return 0; shifts and LUI work on B only.
module ALU
  import alu_pkg::*;
(
  input  logic [3:0]       i_op,
  input  logic [ALU_W-1:0] i_a,
  input  logic [ALU_W-1:0] i_b,
  input  logic [4:0]       i_shamt,
  output logic [ALU_W-1:0] o_result,
  output logic             o_zero
);

  // Select the operation result; add/sub wrap naturally at 32 bits.
  always_comb begin
    // NOTE: default assignment first so every path drives o_result and no latch is inferred.
    o_result = '0;
    case (i_op)
      ALU_OP_AND: o_result = i_a & i_b;
      ALU_OP_OR:  o_result = i_a | i_b;
      ALU_OP_NOR: o_result = ~(i_a | i_b);
      ALU_OP_ADD: o_result = i_a + i_b;
      ALU_OP_SUB: o_result = i_a - i_b;
      ALU_OP_LUI: o_result = {i_b[15:0], 16'h0000};
      ALU_OP_SLL: o_result = i_b << i_shamt;
      ALU_OP_SRL: o_result = i_b >> i_shamt;
      default:    o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-port valid/ready arbiter in front of the shared ALU. One operation in flight:
// IDLE grants and captures operands, EXEC runs the ALU, RESP holds the result until taken.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req_op0,
  input  logic [3:0]       req_op1,
  input  logic [ALU_W-1:0] req_a0,
  input  logic [ALU_W-1:0] req_a1,
  input  logic [ALU_W-1:0] req_b0,
  input  logic [ALU_W-1:0] req_b1,
  input  logic [4:0]       req_shamt0,
  input  logic [4:0]       req_shamt1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [ALU_W-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_illegal
);

  state_t           r_state;
  state_t           w_next_state;
  logic [1:0]       w_grant;
  logic             r_last_grant;
  logic             r_cur_id;
  logic [3:0]       r_op;
  logic [ALU_W-1:0] r_a;
  logic [ALU_W-1:0] r_b;
  logic [4:0]       r_shamt;
  logic [ALU_W-1:0] w_alu_result;
  logic             w_alu_zero;
  logic [ALU_W-1:0] r_rsp_result;
  logic             r_rsp_zero;
  logic             r_rsp_illegal;

  // Arbitration: one-hot grant in IDLE only; a tie goes to the port that did not win last.
  always_comb begin
    w_grant = 2'b00;
    if (r_state == IDLE) begin
      case (req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = (RR_ENABLE && !r_last_grant) ? 2'b10 : 2'b01;
        default: w_grant = 2'b00;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (|w_grant) w_next_state = EXEC;
      EXEC:    w_next_state = RESP;
      RESP:    if (rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM outputs: handshake signals decoded from the current state.
  always_comb begin
    req_ready = w_grant;
    rsp_valid = (r_state == RESP);
  end

  // Operand capture on grant, result capture at the end of EXEC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant  <= 1'b1;
      r_cur_id      <= 1'b0;
      r_op          <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_shamt       <= '0;
      r_rsp_result  <= '0;
      r_rsp_zero    <= 1'b0;
      r_rsp_illegal <= 1'b0;
    end else begin
      if (|w_grant) begin
        r_cur_id     <= w_grant[1];
        r_last_grant <= w_grant[1];
        r_op         <= w_grant[1] ? req_op1    : req_op0;
        r_a          <= w_grant[1] ? req_a1     : req_a0;
        r_b          <= w_grant[1] ? req_b1     : req_b0;
        r_shamt      <= w_grant[1] ? req_shamt1 : req_shamt0;
      end
      if (r_state == EXEC) begin
        r_rsp_result  <= w_alu_result;
        r_rsp_zero    <= w_alu_zero;
        r_rsp_illegal <= r_op[3];
      end
    end
  end

  ALU u_alu (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .i_shamt  (r_shamt),
    .o_result (w_alu_result),
    .o_zero   (w_alu_zero)
  );

  assign rsp_id      = r_cur_id;
  assign rsp_result  = r_rsp_result;
  assign rsp_zero    = r_rsp_zero;
  assign rsp_illegal = r_rsp_illegal;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, streaming arbitration,
// reset mid-operation, and randomized traffic against a behavioural reference model.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [3:0]  req_op0, req_op1;
  logic [31:0] req_a0, req_a1, req_b0, req_b1;
  logic [4:0]  req_shamt0, req_shamt1;
  logic        rsp_ready;

  logic [1:0]  req_ready, fp_req_ready;
  logic        rsp_valid, fp_rsp_valid;
  logic        rsp_id, fp_rsp_id;
  logic [31:0] rsp_result, fp_rsp_result;
  logic        rsp_zero, fp_rsp_zero;
  logic        rsp_illegal, fp_rsp_illegal;

  int n_cmp = 0;
  int n_bad = 0;
  logic model_last;

  alu_arbiter #(.RR_ENABLE(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_shamt0(req_shamt0), .req_shamt1(req_shamt1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal)
  );

  alu_arbiter #(.RR_ENABLE(1'b0)) u_dut_fp (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(fp_req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_shamt0(req_shamt0), .req_shamt1(req_shamt1),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id),
    .rsp_result(fp_rsp_result), .rsp_zero(fp_rsp_zero), .rsp_illegal(fp_rsp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        port;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    int          hold;
    logic [31:0] res;
    logic        zero;
    logic        ill;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input string name, input logic port, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                         input int hold, input logic [31:0] res, input logic zero,
                         input logic ill);
    vec_t v;
    v.name = name; v.port = port; v.op = op; v.a = a; v.b = b; v.sh = sh;
    v.hold = hold; v.res = res; v.zero = zero; v.ill = ill;
    vq.push_back(v);
  endtask

  // Reference ALU written from the op definitions with wide integer arithmetic.
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    longint unsigned t;
    t = 0;
    case (op)
      4'd0: t = a & b;
      4'd1: t = a | b;
      4'd2: t = 64'hFFFF_FFFF - (a | b);
      4'd3: t = longint'(a) + longint'(b);
      4'd4: t = (64'h1_0000_0000 + longint'(a)) - longint'(b);
      4'd5: t = longint'(b % 65536) * 65536;
      4'd6: t = longint'(b) * (64'd1 << sh);
      4'd7: t = longint'(b) / (64'd1 << sh);
      default: t = 0;
    endcase
    return t[31:0];
  endfunction

  task automatic set_port(input logic p, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh);
    if (!p) begin
      req_op0 = op; req_a0 = a; req_b0 = b; req_shamt0 = sh;
    end else begin
      req_op1 = op; req_a1 = a; req_b1 = b; req_shamt1 = sh;
    end
  endtask

  // Enter with time at posedge+1, operands already driven. Leaves at posedge+1 in IDLE.
  task automatic run_txn(input string tag, input logic [1:0] valid, input logic exp_port,
                         input logic [31:0] exp_res, input logic exp_zero,
                         input logic exp_ill, input int hold);
    logic [1:0] exp_rdy;
    int k;
    exp_rdy = exp_port ? 2'b10 : 2'b01;
    req_valid = valid;
    #1;
    k = 0;
    while (req_ready == 2'b00 && k < 8) begin
      @(posedge clk); #2;
      k++;
    end
    if (req_ready == 2'b00) begin
      check({tag, "_grant_timeout"}, 32'(k), 32'd0);
      req_valid = 2'b00;
      return;
    end
    check({tag, "_grant"}, 32'(req_ready), 32'(exp_rdy));
    @(posedge clk); #1;
    req_valid = 2'b00;
    #1;
    check({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_exec_ready"}, 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'(exp_port));
    check({tag, "_rsp_result"}, rsp_result, exp_res);
    check({tag, "_rsp_zero"}, 32'(rsp_zero), 32'(exp_zero));
    check({tag, "_rsp_illegal"}, 32'(rsp_illegal), 32'(exp_ill));
    for (int i = 0; i < hold; i++) begin
      req_valid = 2'b11;
      #1;
      check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_result"}, rsp_result, exp_res);
      check({tag, "_hold_id"}, 32'(rsp_id), 32'(exp_port));
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_back_idle"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    model_last = 1'b1;
  endtask

  initial begin
    int pos[$];
    logic ids[$];
    logic fp_ids[$];
    logic [1:0]  v;
    logic        gp;
    logic [3:0]  op_r [2];
    logic [31:0] a_r [2];
    logic [31:0] b_r [2];
    logic [4:0]  sh_r [2];
    logic [31:0] er;

    reset = 1'b1;
    req_valid = 2'b00; rsp_ready = 1'b0;
    set_port(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    set_port(1'b1, 4'd0, 32'd0, 32'd0, 5'd0);
    model_last = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_zero", 32'(rsp_zero), 32'd0);
    check("rst_rsp_illegal", 32'(rsp_illegal), 32'd0);
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #1;

    // Directed vectors: single-port requests with hand-computed results.
    add_vec("add_5_7",    1'b0, 4'd3,  32'd5,        32'd7,        5'd0,  0, 32'd12,        1'b0, 1'b0);
    add_vec("sub_ff",     1'b1, 4'd4,  32'h0000_00FF, 32'h0000_00FF, 5'd0, 0, 32'd0,         1'b1, 1'b0);
    add_vec("sll_bp",     1'b0, 4'd6,  32'hFFFF_FFFF, 32'd1,        5'd31, 5, 32'h8000_0000, 1'b0, 1'b0);
    add_vec("illegal_f",  1'b1, 4'hF,  32'hDEAD_BEEF, 32'h1234_5678, 5'd3, 0, 32'd0,         1'b1, 1'b1);
    add_vec("after_ill",  1'b1, 4'd3,  32'd100,      32'd23,       5'd0,  0, 32'd123,       1'b0, 1'b0);
    add_vec("nor_0",      1'b1, 4'd2,  32'd0,        32'd0,        5'd0,  0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    add_vec("and",        1'b0, 4'd0,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 0, 32'hF000_F000, 1'b0, 1'b0);
    add_vec("or",         1'b1, 4'd1,  32'h0F0F_0000, 32'h0000_00F0, 5'd0, 1, 32'h0F0F_00F0, 1'b0, 1'b0);
    add_vec("srl_4",      1'b0, 4'd7,  32'hFFFF_FFFF, 32'h8000_0000, 5'd4, 0, 32'h0800_0000, 1'b0, 1'b0);
    add_vec("add_wrap",   1'b0, 4'd3,  32'hFFFF_FFFF, 32'd1,        5'd0,  0, 32'd0,         1'b1, 1'b0);
    add_vec("sub_wrap",   1'b1, 4'd4,  32'd0,        32'd1,        5'd0,  2, 32'hFFFF_FFFF, 1'b0, 1'b0);
    add_vec("lui",        1'b0, 4'd5,  32'hAAAA_AAAA, 32'hFFFF_BEEF, 5'd0, 0, 32'hBEEF_0000, 1'b0, 1'b0);
    add_vec("illegal_8",  1'b0, 4'd8,  32'd1,        32'd1,        5'd0,  0, 32'd0,         1'b1, 1'b1);

    foreach (vq[i]) begin
      set_port(vq[i].port, vq[i].op, vq[i].a, vq[i].b, vq[i].sh);
      run_txn(vq[i].name, vq[i].port ? 2'b10 : 2'b01, vq[i].port, vq[i].res,
              vq[i].zero, vq[i].ill, vq[i].hold);
    end

    // Both ports streaming ADD with rsp_ready high: RR alternates, fixed priority stays on 0.
    do_reset();
    set_port(1'b0, 4'd3, 32'd1, 32'd2, 5'd0);
    set_port(1'b1, 4'd3, 32'd10, 32'd20, 5'd0);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (rsp_valid) begin
        pos.push_back(c);
        ids.push_back(rsp_id);
      end
      if (fp_rsp_valid) fp_ids.push_back(fp_rsp_id);
      @(posedge clk); #2;
    end
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    check("stream_count", 32'(pos.size()), 32'd4);
    check("stream_fp_count", 32'(fp_ids.size()), 32'd4);
    for (int i = 0; i < pos.size() && i < 4; i++) begin
      check($sformatf("stream_cycle_%0d", i), 32'(pos[i]), 32'(2 + 3 * i));
      check($sformatf("stream_rr_id_%0d", i), 32'(ids[i]), 32'(i % 2));
    end
    for (int i = 0; i < fp_ids.size() && i < 4; i++)
      check($sformatf("stream_fp_id_%0d", i), 32'(fp_ids[i]), 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Reset asserted during EXEC: outputs clear at once and no stale response follows.
    do_reset();
    set_port(1'b1, 4'd1, 32'hFFFF_0000, 32'h0000_FFFF, 5'd0);
    req_valid = 2'b10;
    #1;
    check("mid_grant", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    req_valid = 2'b00;
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_id", 32'(rsp_id), 32'd0);
    check("mid_rst_result", rsp_result, 32'd0);
    check("mid_rst_zero", 32'(rsp_zero), 32'd0);
    check("mid_rst_illegal", 32'(rsp_illegal), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    #2 reset = 1'b1;
    model_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("mid_no_stale", 32'(rsp_valid), 32'd0);
    end
    set_port(1'b0, 4'd5, 32'd0, 32'h0000_1234, 5'd0);
    run_txn("mid_lui", 2'b01, 1'b0, 32'h1234_0000, 1'b0, 1'b0, 0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      v = 2'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++) begin
        op_r[p] = 4'($urandom_range(0, 9));
        a_r[p]  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        b_r[p]  = ($urandom_range(0, 7) == 0) ? a_r[p] : $urandom;
        sh_r[p] = 5'($urandom_range(0, 31));
        set_port(p[0], op_r[p], a_r[p], b_r[p], sh_r[p]);
      end
      if (v == 2'b01)      gp = 1'b0;
      else if (v == 2'b10) gp = 1'b1;
      else                 gp = (model_last == 1'b1) ? 1'b0 : 1'b1;
      model_last = gp;
      er = alu_ref(op_r[gp], a_r[gp], b_r[gp], sh_r[gp]);
      run_txn($sformatf("rnd%0d", n), v, gp, er, (er == 32'd0), (op_r[gp] > 4'd7),
              int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
